// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// eth_tx_arbiter : packet round-robin arbiter onto the 64-bit Ethernet TX
//                  stream, with a mid-packet stall watchdog.
// Revision       : 1.0
// ============================================================================
module eth_tx_arbiter #(
   parameter int          NUM_SRC = 3,
   parameter logic [15:0] TIMEOUT = 16'd1024
) (
   input  logic                                          eth_clk,
   input  logic                                          eth_rst,
   input  logic [NUM_SRC-1:0]                            s_tvalid,
   input  logic [NUM_SRC-1:0]                            s_tlast,
   input  logic [NUM_SRC*8-1:0]                          s_tkeep,
   input  logic [NUM_SRC*64-1:0]                         s_tdata,
   output logic [NUM_SRC-1:0]                            s_tready,
   output logic                                          m_tvalid,
   output logic                                          m_tlast,
   output logic [7:0]                                    m_tkeep,
   output logic [63:0]                                   m_tdata,
   input  logic                                          m_tready,
   output logic [(NUM_SRC > 1 ? $clog2(NUM_SRC) : 1)-1:0] grant_id,
   output logic [15:0]                                   abort_cnt
);

   localparam int            GW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [GW-1:0] LAST_IDX = GW'(NUM_SRC - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARB   = 3'd1,
      ST_FWD   = 3'd2,
      ST_ABORT = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   // Reset asserts asynchronously but releases two clocks later, in step with eth_clk.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst;

   always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

   always_ff @(posedge eth_clk or posedge eth_rst) begin
      if (eth_rst) rst_sync_q <= 2'b11;
      else         rst_sync_q <= rst_sync_d;
   end

   assign rst = rst_sync_q[1];

   state_t         state_q, state_d;
   logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]  grant_q, grant_d;
   logic [15:0]    abort_cnt_q, abort_cnt_d;
   logic [15:0]    wdog_q, wdog_d;
   logic           started_q, started_d;

   logic [GW-1:0]  pick, cand, next_ptr;
   logic           found;
   logic           g_valid, g_last, xfer, any_req;
   logic [7:0]     g_keep;
   logic [63:0]    g_data;

   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      cand  = rr_ptr_q;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!found && s_tvalid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
         cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      end
   end

   assign next_ptr = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
   assign g_valid  = s_tvalid[grant_q];
   assign g_last   = s_tlast[grant_q];
   assign g_keep   = s_tkeep[{grant_q, 3'b000} +: 8];
   assign g_data   = s_tdata[{grant_q, 6'b000000} +: 64];
   assign xfer     = g_valid & m_tready;
   assign any_req  = |s_tvalid;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      abort_cnt_d = abort_cnt_q;
      wdog_d      = wdog_q;
      started_d   = started_q;
      m_tvalid    = 1'b0;
      m_tlast     = 1'b0;
      m_tkeep     = 8'h00;
      m_tdata     = 64'h0;
      s_tready    = '0;

      case (state_q)
         ST_IDLE: begin
            if (any_req) state_d = ST_ARB;
         end
         ST_ARB: begin
            wdog_d    = 16'h0;
            started_d = 1'b0;
            if (found) begin
               grant_d = pick;
               state_d = ST_FWD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FWD: begin
            m_tvalid          = g_valid;
            m_tlast           = g_last;
            s_tready[grant_q] = m_tready;
            if (g_valid) begin
               m_tkeep = g_keep;
               m_tdata = g_data;
            end
            // A transfer always beats the watchdog, even on its final cycle.
            if (xfer) begin
               wdog_d    = 16'h0;
               started_d = 1'b1;
               if (g_last) begin
                  rr_ptr_d = next_ptr;
                  state_d  = any_req ? ST_ARB : ST_IDLE;
               end
            end else if (!g_valid && started_q) begin
               if (wdog_q == TIMEOUT - 16'd1) begin
                  wdog_d  = 16'h0;
                  state_d = ST_ABORT;
               end else begin
                  wdog_d = wdog_q + 16'd1;
               end
            end
         end
         ST_ABORT: begin
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
            if (m_tready) begin
               abort_cnt_d = (abort_cnt_q == 16'hFFFF) ? abort_cnt_q : abort_cnt_q + 16'd1;
               rr_ptr_d    = next_ptr;
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            s_tready[grant_q] = 1'b1;
            if (g_valid && g_last) state_d = any_req ? ST_ARB : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge eth_clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         abort_cnt_q <= 16'h0;
         wdog_q      <= 16'h0;
         started_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         abort_cnt_q <= abort_cnt_d;
         wdog_q      <= wdog_d;
         started_q   <= started_d;
      end
   end

   assign grant_id  = grant_q;
   assign abort_cnt = abort_cnt_q;

endmodule
`default_nettype wire
